// File: rtl/nios2_debug_mem_arbiter_pkg.sv
// ============================================================================
// Module      : nios2_debug_mem_pkg
// Description : Shared types and constants for the OCI debug memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nios2_debug_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_JTAG = 2'd1,
        OWN_AVS  = 2'd2
    } owner_t;

    localparam int STARVE_W   = 4;
    localparam int RD_LATENCY = 3;

endpackage

`default_nettype wire

// File: rtl/nios2_debug_mem_arbiter_if.sv
// ============================================================================
// Module      : nios2_debug_mem_arbiter_if
// Description : JTAG command, Avalon-MM slave and OCI RAM signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nios2_debug_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              jtag_cmd_valid;
    logic              jtag_cmd_write;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata;
    logic [DATA_W-1:0] jtag_rdata;
    logic              jtag_rdata_valid;
    logic              jtag_overflow;
    logic              jtag_overflow_clr;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic              avs_waitrequest;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_readdatavalid;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // The arbiter is the slave of both requesters and drives the RAM port.
    modport slave (
        input  jtag_cmd_valid, jtag_cmd_write, jtag_addr, jtag_wdata, jtag_overflow_clr,
        output jtag_rdata, jtag_rdata_valid, jtag_overflow,
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        output ram_addr, ram_wdata, ram_we, ram_re,
        input  ram_rdata
    );

    modport master (
        output jtag_cmd_valid, jtag_cmd_write, jtag_addr, jtag_wdata, jtag_overflow_clr,
        input  jtag_rdata, jtag_rdata_valid, jtag_overflow,
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  ram_addr, ram_wdata, ram_we, ram_re,
        output ram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/nios2_debug_cmd_slot.sv
// ============================================================================
// Module      : nios2_debug_cmd_slot
// Description : One-entry JTAG command capture slot with overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios2_debug_cmd_slot #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic              i_grant,
    input  logic              i_overflow_clr,
    output logic              o_pend,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_overflow
);

    logic              pend_q, pend_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              overflow_q, overflow_d;
    logic              w_drop;
    logic              w_load;

    always_comb begin
        // A slot being granted this cycle is free to accept the incoming command.
        w_drop     = i_cmd_valid & pend_q & ~i_grant;
        w_load     = i_cmd_valid & ~w_drop;
        pend_d     = (pend_q & ~i_grant) | w_load;
        write_d    = w_load ? i_cmd_write : write_q;
        addr_d     = w_load ? i_cmd_addr  : addr_q;
        wdata_d    = w_load ? i_cmd_wdata : wdata_q;
        overflow_d = w_drop | (overflow_q & ~i_overflow_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_pend     = pend_q;
    assign o_write    = write_q;
    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_overflow = overflow_q;

endmodule

`default_nettype wire

// File: rtl/nios2_debug_mem_arbiter.sv
// ============================================================================
// Module      : nios2_debug_mem_arbiter
// Description : Shares the OCI debug RAM between JTAG commands and an Avalon slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios2_debug_mem_arbiter
    import nios2_debug_mem_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    nios2_debug_mem_arbiter_if.slave bus
);

    localparam int                 OWN_STAGES = RD_LATENCY - 1;
    localparam logic [STARVE_W-1:0] LIMIT_C   = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    logic              w_slot_pend;
    logic              w_slot_write;
    logic [ADDR_W-1:0] w_slot_addr;
    logic [DATA_W-1:0] w_slot_wdata;
    logic              w_slot_overflow;
    logic              w_avs_req;
    logic              w_avs_grant;
    logic              w_jtag_grant;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_re_q, ram_re_d;
    owner_t              own_d;
    owner_t              own_q [OWN_STAGES];
    logic [DATA_W-1:0]   jtag_rdata_q, jtag_rdata_d;
    logic                jtag_rvalid_q, jtag_rvalid_d;
    logic [DATA_W-1:0]   avs_rdata_q, avs_rdata_d;
    logic                avs_rvalid_q, avs_rvalid_d;

    nios2_debug_cmd_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk            (clk),
        .reset          (reset),
        .i_cmd_valid    (bus.jtag_cmd_valid),
        .i_cmd_write    (bus.jtag_cmd_write),
        .i_cmd_addr     (bus.jtag_addr),
        .i_cmd_wdata    (bus.jtag_wdata),
        .i_grant        (w_jtag_grant),
        .i_overflow_clr (bus.jtag_overflow_clr),
        .o_pend         (w_slot_pend),
        .o_write        (w_slot_write),
        .o_addr         (w_slot_addr),
        .o_wdata        (w_slot_wdata),
        .o_overflow     (w_slot_overflow)
    );

    always_comb begin
        w_avs_req    = bus.avs_read | bus.avs_write;
        // JTAG wins contention until Avalon has lost STARVE_LIMIT times in a row.
        w_avs_grant  = w_avs_req & (~w_slot_pend | (starve_q >= LIMIT_C));
        w_jtag_grant = w_slot_pend & ~w_avs_grant;

        starve_d = starve_q;
        if (w_avs_grant) begin
            starve_d = '0;
        end else if (w_avs_req && w_slot_pend && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        own_d       = OWN_NONE;
        if (w_avs_grant) begin
            ram_addr_d  = bus.avs_address;
            ram_wdata_d = bus.avs_writedata;
            ram_we_d    = bus.avs_write;
            ram_re_d    = bus.avs_read;
            own_d       = bus.avs_read ? OWN_AVS : OWN_NONE;
        end else if (w_jtag_grant) begin
            ram_addr_d  = w_slot_addr;
            ram_wdata_d = w_slot_wdata;
            ram_we_d    = w_slot_write;
            ram_re_d    = ~w_slot_write;
            own_d       = w_slot_write ? OWN_NONE : OWN_JTAG;
        end

        // The last owner stage lines up with ram_rdata being valid.
        jtag_rvalid_d = (own_q[OWN_STAGES-1] == OWN_JTAG);
        avs_rvalid_d  = (own_q[OWN_STAGES-1] == OWN_AVS);
        jtag_rdata_d  = jtag_rvalid_d ? bus.ram_rdata : jtag_rdata_q;
        avs_rdata_d   = avs_rvalid_d  ? bus.ram_rdata : avs_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q      <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_we_q      <= 1'b0;
            ram_re_q      <= 1'b0;
            for (int i = 0; i < OWN_STAGES; i++) begin
                own_q[i] <= OWN_NONE;
            end
            jtag_rdata_q  <= '0;
            jtag_rvalid_q <= 1'b0;
            avs_rdata_q   <= '0;
            avs_rvalid_q  <= 1'b0;
        end else begin
            starve_q      <= starve_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_we_q      <= ram_we_d;
            ram_re_q      <= ram_re_d;
            own_q[0]      <= own_d;
            for (int i = 1; i < OWN_STAGES; i++) begin
                own_q[i] <= own_q[i-1];
            end
            jtag_rdata_q  <= jtag_rdata_d;
            jtag_rvalid_q <= jtag_rvalid_d;
            avs_rdata_q   <= avs_rdata_d;
            avs_rvalid_q  <= avs_rvalid_d;
        end
    end

    assign bus.avs_waitrequest   = w_avs_req & ~w_avs_grant;
    assign bus.avs_readdata      = avs_rdata_q;
    assign bus.avs_readdatavalid = avs_rvalid_q;
    assign bus.jtag_rdata        = jtag_rdata_q;
    assign bus.jtag_rdata_valid  = jtag_rvalid_q;
    assign bus.jtag_overflow     = w_slot_overflow;
    assign bus.ram_addr          = ram_addr_q;
    assign bus.ram_wdata         = ram_wdata_q;
    assign bus.ram_we            = ram_we_q;
    assign bus.ram_re            = ram_re_q;

endmodule

`default_nettype wire

// File: doc/nios2_debug_mem_arbiter.md
Name: nios2_debug_mem_arbiter

Overview:
Shares the single-port on-chip debug memory (OCI RAM) between two requesters: the JTAG debug-host command path (sysclk-side action pulses carrying address and data) and an Avalon-MM debug slave used by CPU-side software. JTAG commands cannot be back-pressured, so they are captured into a one-entry slot and normally win arbitration. A starvation counter guarantees Avalon progress. Read data is returned to the owner that issued the read.

Parameters:
ADDR_W, 8, OCI RAM word-address width.
DATA_W, 32, data width of the RAM and both requesters.
STARVE_LIMIT, 4, number of consecutive Avalon losses before Avalon is forced to win; legal range 1..15.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
jtag_cmd_valid  in  1  one-cycle command pulse from the JTAG sysclk decoder.
jtag_cmd_write  in  1  1 = write, 0 = read; qualified by jtag_cmd_valid.
jtag_addr  in  ADDR_W  command address.
jtag_wdata  in  DATA_W  write data.
jtag_rdata  out  DATA_W  read data returned to JTAG.
jtag_rdata_valid  out  1  one-cycle pulse qualifying jtag_rdata.
jtag_overflow  out  1  sticky; a JTAG command was dropped.
jtag_overflow_clr  in  1  clears jtag_overflow.
avs_address  in  ADDR_W  Avalon word address.
avs_read  in  1  Avalon read request.
avs_write  in  1  Avalon write request; read and write are never both high.
avs_writedata  in  DATA_W  Avalon write data.
avs_waitrequest  out  1  Avalon stall.
avs_readdata  out  DATA_W  Avalon read data.
avs_readdatavalid  out  1  one-cycle pulse qualifying avs_readdata.
ram_addr  out  ADDR_W  RAM address, registered.
ram_wdata  out  DATA_W  RAM write data, registered.
ram_we  out  1  RAM write enable, registered.
ram_re  out  1  RAM read enable, registered.
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re.

Behaviour:
- Reset: all outputs 0, except avs_waitrequest, which is combinational (see below). Slot empty, starve_cnt 0, read-owner pipeline cleared. On reset mid-read, the in-flight read is discarded and no rdata_valid pulse follows.
- Slot capture:
  - jtag_cmd_valid in cycle N loads the slot (pend=1, write flag, addr, wdata).
  - The slot is eligible for arbitration from cycle N+1.
- Arbitration, evaluated every cycle; candidates are pend and avs_req = avs_read|avs_write:
  - Only one candidate present: that candidate wins.
  - Both present and starve_cnt < STARVE_LIMIT: JTAG wins, and starve_cnt increments (saturating at 15).
  - Both present and starve_cnt == STARVE_LIMIT: Avalon wins.
  - Any Avalon grant clears starve_cnt. starve_cnt is unchanged on cycles where Avalon is not requesting.
- avs_waitrequest = avs_req & ~avs_grant, combinational. When Avalon is idle it is 0.
- Issue on a grant in cycle N:
  - In N+1, ram_addr, ram_wdata, ram_we or ram_re carry the winning command.
  - ram_we and ram_re are 0 on cycles with no grant.
  - A JTAG grant clears pend at the N→N+1 edge.
- Read return:
  - Owner tag pipeline: 2 bits, OWN_NONE / OWN_JTAG / OWN_AVS.
  - ram_rdata is sampled in N+2.
  - The owner's rdata/valid outputs are registered, with the valid pulse in N+3.
  - Total read latency is 3 cycles from grant for both requesters.
  - Fully pipelined: one grant per cycle, with no bubbles between back-to-back reads.
- Overflow:
  - jtag_cmd_valid while pend=1 and the slot is not granted that cycle: the new command is dropped and jtag_overflow is set.
  - jtag_cmd_valid in the same cycle the slot is granted: the slot reloads and there is no overflow.
  - jtag_overflow_clr in the same cycle as a new overflow: set wins.
- Writes return nothing. Read-after-write to the same address from either requester returns the new data, because RAM order equals grant order.

Decomposition:
- Shared package nios2_debug_mem_pkg holds:
  - owner_t enum: OWN_NONE=0, OWN_JTAG=1, OWN_AVS=2.
  - Starve counter width constant: 4.
  - Read latency constant: 3.
- One natural sub-module, nios2_debug_cmd_slot. It is the one-entry JTAG capture register with pend, the reload-on-grant rule and overflow detection.

Test Plan:
1. JTAG write addr 0x10, data 0xCAFEF00D, then JTAG read 0x10 → ram_we in cycle N+1 (N = slot grant cycle); jtag_rdata_valid 3 cycles after the read grant with 0xCAFEF00D; avs_readdatavalid stays 0.
2. Avalon held read 0x20 with no JTAG activity → waitrequest 0; readdatavalid exactly 3 cycles later; 8 back-to-back reads give 8 consecutive valid pulses.
3. JTAG pulse every cycle for 10 cycles while Avalon reads continuously, STARVE_LIMIT=4 → Avalon granted on the 5th contended cycle; waitrequest low exactly that cycle; starve_cnt returns to 0.
4. Two JTAG pulses 1 cycle apart while Avalon holds the slot off, STARVE_LIMIT=1 → second command dropped, jtag_overflow=1 and remains set until jtag_overflow_clr; simultaneous clr and new overflow → stays 1.
5. JTAG pulse in the same cycle the slot is granted → reload, no overflow; both commands reach the RAM in order.
6. Assert reset 1 cycle after a JTAG read grant → all outputs 0; no jtag_rdata_valid after release; next read returns correctly.
